// File: rtl/cell_plotter.sv
// Cell plotter: queues cell-update requests and expands each into a block
// of pixel writes for the vga_adapter, with an on-demand black grid fill.
module cell_plotter #(
    parameter int CELL_SIZE  = 4,
    parameter int GRID_DIM   = 4,
    parameter int ORIGIN_X   = 0,
    parameter int ORIGIN_Y   = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_x,
    input  logic [7:0] in_y,
    input  logic [2:0] in_color,
    input  logic       clear,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH     = FIFO_DEPTH[AW:0];
    localparam logic [7:0]  CS_LAST   = 8'(CELL_SIZE - 1);
    localparam logic [7:0]  GRID_LAST = 8'(GRID_DIM * CELL_SIZE - 1);
    localparam logic [8:0]  GRID_LIM  = 9'(GRID_DIM);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLOT,
        CLEAR
    } state_t;

    state_t state_q, state_d;

    logic [18:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    logic       clear_pending_q, clear_pending_d;
    logic [7:0] base_x_q, base_x_d;
    logic [7:0] base_y_q, base_y_d;
    logic [2:0] color_q, color_d;
    logic [7:0] dx_q, dx_d;
    logic [7:0] dy_q, dy_d;

    logic [7:0] vga_x_q, vga_x_d;
    logic [7:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;

    logic       push, pop, empty;
    logic [7:0] head_x, head_y, last;
    logic [2:0] head_c;

    assign in_ready   = (count_q != DEPTH);
    assign empty      = (count_q == '0);
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == LOAD);
    assign head_x     = mem_q[rptr_q][18:11];
    assign head_y     = mem_q[rptr_q][10:3];
    assign head_c     = mem_q[rptr_q][2:0];
    assign busy       = !(state_q == IDLE && empty && !clear_pending_q);
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        clear_pending_d = clear_pending_q | clear;
        base_x_d        = base_x_q;
        base_y_d        = base_y_q;
        color_d         = color_q;
        dx_d            = dx_q;
        dy_d            = dy_q;
        last            = (state_q == CLEAR) ? GRID_LAST : CS_LAST;

        unique case (state_q)
            IDLE: begin
                if (clear_pending_q) begin
                    // a pulse arriving now re-arms the next fill
                    state_d         = CLEAR;
                    clear_pending_d = clear;
                    base_x_d        = 8'(ORIGIN_X);
                    base_y_d        = 8'(ORIGIN_Y);
                    color_d         = 3'b000;
                    dx_d            = 8'd0;
                    dy_d            = 8'd0;
                end else if (!empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                color_d = head_c;
                if ({1'b0, head_x} < GRID_LIM && {1'b0, head_y} < GRID_LIM) begin
                    state_d  = PLOT;
                    base_x_d = 8'(ORIGIN_X) + 8'(32'(head_x) * CELL_SIZE);
                    base_y_d = 8'(ORIGIN_Y) + 8'(32'(head_y) * CELL_SIZE);
                    dx_d     = 8'd0;
                    dy_d     = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            PLOT, CLEAR: begin
                if (dx_q == last) begin
                    dx_d = 8'd0;
                    if (dy_q == last) begin
                        state_d = IDLE;
                    end else begin
                        dy_d = dy_q + 8'd1;
                    end
                end else begin
                    dx_d = dx_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // outputs follow the state being entered, so they line up with it
        vga_plot_d   = (state_d == PLOT) || (state_d == CLEAR);
        vga_x_d      = vga_plot_d ? base_x_d + dx_d : vga_x_q;
        vga_y_d      = vga_plot_d ? base_y_d + dy_d : vga_y_q;
        vga_colour_d = vga_plot_d ? color_d : vga_colour_q;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q] <= {in_x, in_y, in_color};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            clear_pending_q <= 1'b0;
            base_x_q        <= 8'd0;
            base_y_q        <= 8'd0;
            color_q         <= 3'b000;
            dx_q            <= 8'd0;
            dy_q            <= 8'd0;
            vga_x_q         <= 8'd0;
            vga_y_q         <= 8'd0;
            vga_colour_q    <= 3'b000;
            vga_plot_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            clear_pending_q <= clear_pending_d;
            base_x_q        <= base_x_d;
            base_y_q        <= base_y_d;
            color_q         <= color_d;
            dx_q            <= dx_d;
            dy_q            <= dy_d;
            vga_x_q         <= vga_x_d;
            vga_y_q         <= vga_y_d;
            vga_colour_q    <= vga_colour_d;
            vga_plot_q      <= vga_plot_d;
        end
    end

endmodule

// File: tb/tb_cell_plotter.sv
// Directed bench for cell_plotter: plots are captured on the falling edge
// and compared against hand-derived raster blocks.
module tb_cell_plotter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_x = 8'd0;
    logic [7:0] in_y = 8'd0;
    logic [2:0] in_color = 3'd0;
    logic       clear = 1'b0;
    logic [7:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
        int         t;
    } pix_t;

    pix_t plots[$];

    cell_plotter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_color  (in_color),
        .clear     (clear),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset_n && vga_plot === 1'b1) begin
            plots.push_back('{vga_x, vga_y, vga_colour, cyc});
        end
    end

    // mismatching pixels of a w x w raster block expected at plots[off]
    function automatic int block_errs(int off, int bx, int by, int c, int w);
        int e = 0;
        for (int k = 0; k < w * w; k++) begin
            if (off + k >= plots.size()) begin
                e++;
            end else if (plots[off+k].x !== 8'(bx + k % w) ||
                         plots[off+k].y !== 8'(by + k / w) ||
                         plots[off+k].c !== 3'(c)) begin
                e++;
            end
        end
        return e;
    endfunction

    task automatic push_req(input logic [7:0] x, input logic [7:0] y,
                            input logic [2:0] c, output int t);
        in_x = x;
        in_y = y;
        in_color = c;
        in_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (in_ready) break;
            @(negedge clock);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clock);
        @(negedge clock);
        t = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clock);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        int t;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({vga_x, vga_y, vga_colour, vga_plot} !== 20'd0) begin
            fails++;
            $display("FAIL reset_vga: x=%0d y=%0d c=%0d plot=%b required 0",
                     vga_x, vga_y, vga_colour, vga_plot);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: in_ready=%b busy=%b required 1/0",
                     in_ready, busy);
        end
        reset_n = 1'b1;
        @(negedge clock);

        push_req(8'd1, 8'd1, 3'd7, t);
        for (int i = 0; i < 10; i++) begin
            if (vga_plot) break;
            @(negedge clock);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (vga_plot !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_plot: plot=%b in_ready=%b required 0/1",
                     vga_plot, in_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        plots.delete();
        repeat (20) @(negedge clock);
        checks++;
        if (plots.size() !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: plots=%0d busy=%b required 0/0",
                     plots.size(), busy);
        end
    endtask

    task automatic test_single();
        int n;
        int idle_t;
        plots.delete();
        push_req(8'd2, 8'd1, 3'd7, n);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(negedge clock);
        end
        idle_t = cyc;
        checks++;
        if (idle_t !== n + 18) begin
            fails++;
            $display("FAIL single_busy: idle at %0d required %0d", idle_t, n + 18);
        end
        checks++;
        if (plots.size() !== 16) begin
            fails++;
            $display("FAIL single_count: %0d plots required 16", plots.size());
        end
        checks++;
        if (plots.size() == 0 || plots[0].t !== n + 2) begin
            fails++;
            $display("FAIL single_latency: first plot at %0d required %0d",
                     plots.size() == 0 ? -1 : plots[0].t, n + 2);
        end
        checks++;
        if (block_errs(0, 8, 4, 7, 4) !== 0) begin
            fails++;
            $display("FAIL single_pixels: %0d bad pixels required 0",
                     block_errs(0, 8, 4, 7, 4));
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int held;
        plots.delete();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_req(8'(i % 4), 8'(i / 4), 3'((i % 7) + 1), t);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_full: in_ready=%b required 0", in_ready);
        end
        in_x = 8'd0;
        in_y = 8'd0;
        in_color = 3'd3;
        in_valid = 1'b1;
        held = 0;
        while (!in_ready && held < 600) begin
            @(negedge clock);
            held++;
        end
        checks++;
        if (held < 200 || held >= 600) begin
            fails++;
            $display("FAIL b2b_held: held %0d cycles required 200..599", held);
        end
        checks++;
        if (plots.size() < 256 || plots.size() > 257) begin
            fails++;
            $display("FAIL b2b_accept_point: %0d plots at accept required 256..257",
                     plots.size());
        end
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        wait_idle(1000);
        checks++;
        if (plots.size() !== 256 + 17 * 16) begin
            fails++;
            $display("FAIL b2b_count: %0d plots required %0d",
                     plots.size(), 256 + 17 * 16);
        end
        checks++;
        if (block_errs(0, 0, 0, 0, 16) !== 0) begin
            fails++;
            $display("FAIL b2b_clear: %0d bad pixels required 0",
                     block_errs(0, 0, 0, 0, 16));
        end
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (block_errs(256 + 16 * i, 4 * (i % 4), 4 * ((i / 4) % 4),
                           (i % 7) + 1, 4) !== 0) begin
                fails++;
                $display("FAIL b2b_cell%0d: bad pixels %0d required 0", i,
                         block_errs(256 + 16 * i, 4 * (i % 4),
                                    4 * ((i / 4) % 4), (i % 7) + 1, 4));
            end
        end
    endtask

    task automatic test_out_of_range();
        int t;
        plots.delete();
        push_req(8'd4, 8'd0, 3'd7, t);
        push_req(8'd0, 8'd0, 3'd7, t);
        wait_idle(100);
        checks++;
        if (plots.size() !== 16) begin
            fails++;
            $display("FAIL oor_count: %0d plots required 16", plots.size());
        end
        checks++;
        if (block_errs(0, 0, 0, 7, 4) !== 0) begin
            fails++;
            $display("FAIL oor_pixels: %0d bad pixels required 0",
                     block_errs(0, 0, 0, 7, 4));
        end
    endtask

    task automatic test_clear_mid();
        int t;
        plots.delete();
        push_req(8'd1, 8'd2, 3'd7, t);
        push_req(8'd3, 8'd3, 3'd2, t);
        push_req(8'd2, 8'd0, 3'd5, t);
        push_req(8'd0, 8'd3, 3'd1, t);
        for (int i = 0; i < 20; i++) begin
            if (plots.size() >= 4) break;
            @(negedge clock);
        end
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        wait_idle(1000);
        checks++;
        if (plots.size() !== 320) begin
            fails++;
            $display("FAIL clrmid_count: %0d plots required 320", plots.size());
        end
        checks++;
        if (block_errs(0, 4, 8, 7, 4) !== 0) begin
            fails++;
            $display("FAIL clrmid_first: %0d bad pixels required 0",
                     block_errs(0, 4, 8, 7, 4));
        end
        checks++;
        if (block_errs(16, 0, 0, 0, 16) !== 0) begin
            fails++;
            $display("FAIL clrmid_fill: %0d bad pixels required 0",
                     block_errs(16, 0, 0, 0, 16));
        end
        checks++;
        if (block_errs(272, 12, 12, 2, 4) + block_errs(288, 8, 0, 5, 4) +
            block_errs(304, 0, 12, 1, 4) !== 0) begin
            fails++;
            $display("FAIL clrmid_queued: %0d bad pixels required 0",
                     block_errs(272, 12, 12, 2, 4) + block_errs(288, 8, 0, 5, 4) +
                     block_errs(304, 0, 12, 1, 4));
        end
    endtask

    task automatic test_push_pop();
        int ta;
        int tb;
        plots.delete();
        push_req(8'd3, 8'd0, 3'd6, ta);
        @(negedge clock);
        push_req(8'd1, 8'd3, 3'd4, tb);
        checks++;
        if (tb !== ta + 2) begin
            fails++;
            $display("FAIL pp_align: second accept at %0d required %0d", tb, ta + 2);
        end
        wait_idle(100);
        checks++;
        if (plots.size() !== 32) begin
            fails++;
            $display("FAIL pp_count: %0d plots required 32", plots.size());
        end
        checks++;
        if (block_errs(0, 12, 0, 6, 4) + block_errs(16, 4, 12, 4, 4) !== 0) begin
            fails++;
            $display("FAIL pp_pixels: %0d bad pixels required 0",
                     block_errs(0, 12, 0, 6, 4) + block_errs(16, 4, 12, 4, 4));
        end
        checks++;
        if (plots.size() < 17 || plots[16].t !== ta + 20) begin
            fails++;
            $display("FAIL pp_second_start: at %0d required %0d",
                     plots.size() < 17 ? -1 : plots[16].t, ta + 20);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_range();
        test_clear_mid();
        test_push_pop();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
